// File: rtl/seg_hex_display_pkg.sv
// Shared constants for the two-digit hex scanner: segment bit positions,
// digit-select values and the nibble-to-segment table.
package seg_hex_display_pkg;

    // Bit positions inside the 8-bit segment bus {a,b,c,d,e,f,g,dp}.
    localparam int unsigned SEG_A  = 7;
    localparam int unsigned SEG_G  = 1;
    localparam int unsigned SEG_DP = 0;

    localparam logic DIG_LO = 1'b0;
    localparam logic DIG_HI = 1'b1;

    // Active-high {a..g} pattern for each hex nibble, entry 0 first.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    function automatic logic [6:0] hex_lookup(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

endpackage

// File: rtl/seg_hex_display_hex7seg.sv
// Combinational nibble decoder; produces active-high {a..g}.
module hex7seg
    import seg_hex_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = hex_lookup(nibble_i);
    end

endmodule

// File: rtl/seg_hex_display.sv
// Two-digit multiplexed hex display with a one-deep pending buffer that is
// only committed to the displayed byte at frame end.
module seg_hex_display
    import seg_hex_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 50000,
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter bit          BLANK_LZ   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] seg,
    output logic [1:0] an,
    output logic [7:0] shown
);

    localparam int unsigned   CW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    // Reset display: digit 0 showing '0' with dp off.
    localparam logic [7:0] SEG_AH_RST = {HEX_SEG[0], 1'b0};
    localparam logic [1:0] AN_AH_RST  = 2'b01;
    localparam logic [7:0] SEG_RST    = ACTIVE_LOW ? ~SEG_AH_RST : SEG_AH_RST;
    localparam logic [1:0] AN_RST     = ACTIVE_LOW ? ~AN_AH_RST : AN_AH_RST;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          digit_q, digit_d;
    logic          pend_full_q, pend_full_d;
    logic [7:0]    pend_data_q, pend_data_d;
    logic [7:0]    shown_q, shown_d;
    logic [7:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;

    logic          scan_tick;
    logic          frame_end;
    logic          accept;
    logic [3:0]    nibble;
    logic [6:0]    dec_seg;
    logic [7:0]    seg_ah;
    logic [1:0]    an_ah;

    hex7seg u_hex7seg (
        .nibble_i (nibble),
        .seg_o    (dec_seg)
    );

    always_comb begin
        scan_tick = (cnt_q == CNT_LAST);
        frame_end = scan_tick && (digit_q == DIG_HI);
        accept    = in_valid && !pend_full_q;

        cnt_d     = scan_tick ? '0 : cnt_q + CW'(1);
        digit_d   = digit_q ^ scan_tick;

        pend_full_d = pend_full_q;
        pend_data_d = pend_data_q;
        shown_d     = shown_q;
        // accept requires an empty buffer, so it never collides with a commit
        if (frame_end && pend_full_q) begin
            shown_d     = pend_data_q;
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pend_data_d = in_data;
            pend_full_d = 1'b1;
        end
    end

    always_comb begin
        nibble = (digit_q == DIG_HI) ? shown_q[7:4] : shown_q[3:0];

        seg_ah                = '0;
        seg_ah[SEG_A:SEG_G]   = dec_seg;
        seg_ah[SEG_DP]        = (digit_q == DIG_LO) && pend_full_q;
        if (BLANK_LZ && (digit_q == DIG_HI) && (shown_q[7:4] == 4'h0)) begin
            seg_ah = '0;
        end
        an_ah = (digit_q == DIG_HI) ? 2'b10 : 2'b01;

        seg_d = ACTIVE_LOW ? ~seg_ah : seg_ah;
        an_d  = ACTIVE_LOW ? ~an_ah  : an_ah;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            digit_q     <= DIG_LO;
            pend_full_q <= 1'b0;
            pend_data_q <= '0;
            shown_q     <= '0;
            seg_q       <= SEG_RST;
            an_q        <= AN_RST;
        end else begin
            cnt_q       <= cnt_d;
            digit_q     <= digit_d;
            pend_full_q <= pend_full_d;
            pend_data_q <= pend_data_d;
            shown_q     <= shown_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign in_ready = !pend_full_q;
    assign shown    = shown_q;
    assign seg      = seg_q;
    assign an       = an_q;

endmodule

// File: tb/tb_seg_hex_display.sv
// Bench for seg_hex_display: two instances (leading-zero blanking off/on)
// driven together and compared against a cycle-count based reference model.
module tb_seg_hex_display;

    localparam int unsigned SD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic       in_ready, in_ready_b;
    logic [7:0] seg, seg_b, shown, shown_b;
    logic [1:0] an, an_b;

    int checks = 0;
    int errors = 0;

    // reference model state
    int unsigned m_k;
    logic        m_pend;
    logic [7:0]  m_pdata;
    logic [7:0]  m_shown;
    logic        m_acc;
    logic [7:0]  e_seg, e_seg_b;
    logic [1:0]  e_an;

    logic [6:0] hex_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    seg_hex_display #(.SCAN_DIV(SD), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .seg(seg), .an(an), .shown(shown)
    );

    seg_hex_display #(.SCAN_DIV(SD), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_b), .seg(seg_b), .an(an_b), .shown(shown_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Active-low segment word for a digit, built straight from the table.
    function automatic logic [7:0] disp(input int unsigned dig, input logic [7:0] sh,
                                        input logic pend, input bit blank);
        logic [7:0] ah;
        logic [3:0] nib;
        nib = (dig == 1) ? sh[7:4] : sh[3:0];
        ah  = {hex_tab[nib], (dig == 0) && pend};
        if (blank && dig == 1 && sh[7:4] == 4'h0) ah = 8'h00;
        return ~ah;
    endfunction

    task automatic model_reset();
        m_k = 0; m_pend = 1'b0; m_pdata = 8'h00; m_shown = 8'h00; m_acc = 1'b0;
    endtask

    // One clock: drive inputs, advance past the edge, update the model.
    task automatic step(input logic v, input logic [7:0] d);
        int unsigned dig;
        bit fe;
        in_valid = v;
        in_data  = d;
        dig      = (m_k / SD) % 2;
        fe       = (m_k % (2 * SD)) == (2 * SD - 1);
        e_seg    = disp(dig, m_shown, m_pend, 1'b0);
        e_seg_b  = disp(dig, m_shown, m_pend, 1'b1);
        e_an     = (dig == 1) ? 2'b01 : 2'b10;
        m_acc    = v && !m_pend;
        @(posedge clk);
        #1;
        if (fe && m_pend) begin
            m_shown = m_pdata;
            m_pend  = 1'b0;
        end
        if (m_acc) begin
            m_pdata = d;
            m_pend  = 1'b1;
        end
        m_k++;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if ({in_ready, shown, seg, an} !== {1'b1, 8'h00, 8'b00000011, 2'b10}) begin
            errors++;
            $display("FAIL reset_state got rdy=%b shown=%h seg=%b an=%b want rdy=1 shown=00 seg=00000011 an=10",
                     in_ready, shown, seg, an);
        end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'($urandom));
            checks++;
            if ({in_ready, shown, seg, an, seg_b, an_b} !== {!m_pend, m_shown, e_seg, e_an, e_seg_b, e_an}) begin
                errors++;
                $display("FAIL reset_scan k=%0d got rdy=%b shown=%h seg=%b an=%b seg_b=%b want rdy=%b shown=%h seg=%b an=%b seg_b=%b",
                         m_k, in_ready, shown, seg, an, seg_b, !m_pend, m_shown, e_seg, e_an, e_seg_b);
            end
        end
    endtask

    task automatic test_single_byte();
        int n;
        step(1'b1, 8'h3A);
        n = 0;
        while (m_pend && n < 2 * SD + 2) begin
            checks++;
            if ({in_ready, shown, seg, an} !== {!m_pend, m_shown, e_seg, e_an}) begin
                errors++;
                $display("FAIL single_wait k=%0d got rdy=%b shown=%h seg=%b an=%b want rdy=%b shown=%h seg=%b an=%b",
                         m_k, in_ready, shown, seg, an, !m_pend, m_shown, e_seg, e_an);
            end
            step(1'b0, 8'($urandom));
            n++;
        end
        checks++;
        if (shown !== 8'h3A) begin
            errors++;
            $display("FAIL single_shown got %h want 3a", shown);
        end
        for (int i = 0; i < 2 * SD + 2; i++) begin
            step(1'b0, 8'($urandom));
            if (i >= 1) begin
                checks++;
                if ((an == 2'b10 && seg !== 8'b00010001) || (an == 2'b01 && seg !== 8'b00001101) ||
                    seg !== e_seg || an !== e_an) begin
                    errors++;
                    $display("FAIL single_digits k=%0d got seg=%b an=%b want seg=%b an=%b",
                             m_k, seg, an, e_seg, e_an);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seen [$];
        logic [7:0] last;
        int n;
        last = shown;
        n = 0;
        for (int phase = 0; phase < 3; phase++) begin
            do begin
                if (phase == 0) step(1'b1, 8'h11);
                else if (phase == 1) step(1'b1, 8'h22);
                else step(1'b0, 8'h5C);
                n++;
                checks++;
                if ({in_ready, shown, seg, an} !== {!m_pend, m_shown, e_seg, e_an}) begin
                    errors++;
                    $display("FAIL b2b_cycle k=%0d got rdy=%b shown=%h seg=%b an=%b want rdy=%b shown=%h seg=%b an=%b",
                             m_k, in_ready, shown, seg, an, !m_pend, m_shown, e_seg, e_an);
                end
                if (shown !== last) begin
                    seen.push_back(shown);
                    last = shown;
                end
            end while (((phase < 2) ? !m_acc : m_pend) && n < 8 * SD);
        end
        checks++;
        if (n >= 8 * SD) begin
            errors++;
            $display("FAIL b2b_timeout got %0d cycles want < %0d", n, 8 * SD);
        end
        checks++;
        if (seen.size() < 2 || seen[seen.size()-2] !== 8'h11 || seen[seen.size()-1] !== 8'h22) begin
            errors++;
            $display("FAIL b2b_sequence got %0d changes last=%h want ... 11 22", seen.size(), last);
        end
    endtask

    task automatic test_frame_end_accept();
        logic [7:0] old;
        int n;
        n = 0;
        while (!((m_k % (2 * SD)) == (2 * SD - 1) && !m_pend) && n < 6 * SD) begin
            step(1'b0, 8'h00);
            n++;
        end
        old = m_shown;
        step(1'b1, 8'hC4);
        checks++;
        if (shown !== old || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fe_accept_edge got shown=%h rdy=%b want shown=%h rdy=0", shown, in_ready, old);
        end
        for (int i = 1; i <= 2 * SD; i++) begin
            step(1'b0, 8'($urandom));
            checks++;
            if (shown !== ((i < 2 * SD) ? old : 8'hC4) || {seg, an, in_ready} !== {e_seg, e_an, !m_pend}) begin
                errors++;
                $display("FAIL fe_accept_wait i=%0d got shown=%h seg=%b an=%b rdy=%b want shown=%h seg=%b an=%b rdy=%b",
                         i, shown, seg, an, in_ready, (i < 2 * SD) ? old : 8'hC4, e_seg, e_an, !m_pend);
            end
        end
    endtask

    task automatic test_blank();
        logic [7:0] vals [2];
        logic [7:0] want_lo [2];
        int n;
        vals[0] = 8'h05; want_lo[0] = 8'b01001001;
        vals[1] = 8'h00; want_lo[1] = 8'b00000011;
        for (int v = 0; v < 2; v++) begin
            n = 0;
            step(1'b1, vals[v]);
            while (m_pend && n < 4 * SD) begin
                step(1'b0, 8'($urandom));
                n++;
            end
            step(1'b0, 8'h00);
            for (int i = 0; i < 2 * SD; i++) begin
                step(1'b0, 8'($urandom));
                checks++;
                if (shown_b !== vals[v] || seg_b !== e_seg_b || seg !== e_seg ||
                    (an_b == 2'b01 && seg_b !== 8'b11111111) ||
                    (an_b == 2'b10 && seg_b !== want_lo[v])) begin
                    errors++;
                    $display("FAIL blank_lz v=%h got shown=%h seg_b=%b an_b=%b seg=%b want seg_b=%b seg=%b",
                             vals[v], shown_b, seg_b, an_b, seg, e_seg_b, e_seg);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 2) == 0, 8'($urandom));
            checks++;
            if ({in_ready, shown, seg, an, in_ready_b, shown_b, seg_b, an_b} !==
                {!m_pend, m_shown, e_seg, e_an, !m_pend, m_shown, e_seg_b, e_an}) begin
                errors++;
                $display("FAIL random k=%0d got rdy=%b shown=%h seg=%b an=%b seg_b=%b want rdy=%b shown=%h seg=%b an=%b seg_b=%b",
                         m_k, in_ready, shown, seg, an, seg_b, !m_pend, m_shown, e_seg, e_an, e_seg_b);
            end
        end
    endtask

    task automatic test_reset_pending();
        int n;
        n = 0;
        while (m_pend && n < 4 * SD) begin
            step(1'b0, 8'h00);
            n++;
        end
        step(1'b1, 8'h77);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, in_ready_b, shown, seg, an} !== {1'b1, 1'b1, 8'h00, 8'b00000011, 2'b10}) begin
            errors++;
            $display("FAIL reset_async got rdy=%b rdy_b=%b shown=%h seg=%b an=%b want rdy=1 rdy_b=1 shown=00 seg=00000011 an=10",
                     in_ready, in_ready_b, shown, seg, an);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4 * SD; i++) begin
            step(1'b0, 8'($urandom));
            checks++;
            if ({in_ready, shown, seg, an} !== {!m_pend, m_shown, e_seg, e_an} || shown !== 8'h00) begin
                errors++;
                $display("FAIL reset_drop k=%0d got rdy=%b shown=%h seg=%b an=%b want rdy=%b shown=00 seg=%b an=%b",
                         m_k, in_ready, shown, seg, an, !m_pend, e_seg, e_an);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_frame_end_accept();
        test_blank();
        test_random();
        test_reset_pending();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_hex_display.md
SEG_HEX_DISPLAY -- requirements
Module: seg_hex_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning the number of clk cycles each digit is enabled (legal range 2 or more).
REQ-002 SHALL have parameter ACTIVE_LOW, default 1: 1 means seg and an are driven inverted (0 = lit/enabled); 0 means active-high.
REQ-003 SHALL have parameter BLANK_LZ, default 0: 1 means the high digit is blanked when shown[7:4] == 0.
REQ-004 clk  input  1  single clock; all state on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  upstream (shift/LFSR stage) presents a new byte.
REQ-007 in_data  input  8  byte to display.
REQ-008 in_ready  output  1  block can accept a byte this cycle.
REQ-009 seg  output  8  segments {a,b,c,d,e,f,g,dp}, bit 7 = a, bit 0 = dp.
REQ-010 an  output  2  digit enables; an[0] = low nibble, an[1] = high nibble.
REQ-011 shown  output  8  byte currently being displayed.

Function
REQ-012 SHALL accept in_data when in_valid && in_ready at a rising clk, storing it in a pending register and setting pend_full.
REQ-013 in_ready SHALL equal !pend_full; in_data SHALL be ignored when in_valid is low or in_ready is low.
REQ-014 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; scan_tick SHALL be asserted when the count is SCAN_DIV-1.
REQ-015 On scan_tick the digit select SHALL toggle (0->1, 1->0).
REQ-016 Frame end is defined as scan_tick while digit == 1.
REQ-017 At frame end with pend_full set, the block SHALL copy pending to shown and clear pend_full in the same cycle, so shown never changes mid-frame.
REQ-018 Simultaneous accept and frame end: frame end sees pend_full = 0 and does nothing; the accepted byte enters pending and is shown at the next frame end.
REQ-019 Latency from accept to shown update: 1 to 2*SCAN_DIV clk cycles, depending on scan phase.
REQ-020 The segment nibble SHALL be shown[3:0] when digit == 0 and shown[7:4] when digit == 1.
REQ-021 Hex decode patterns {a..g}, active-high: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-022 dp SHALL be lit only on digit 0 while pend_full == 1 (update pending indicator).
REQ-023 If BLANK_LZ == 1 and digit == 1 and shown[7:4] == 0, all eight segments SHALL be off.
REQ-024 an (active-high form) SHALL be 2'b01 for digit 0 and 2'b10 for digit 1; exactly one digit is enabled at a time.
REQ-025 seg and an SHALL be registered: they reflect the digit and shown values one cycle after those values change.
REQ-026 With ACTIVE_LOW == 1, seg and an SHALL be the bitwise inverse of the active-high forms.

Reset
REQ-027 While rst is high: shown = 8'h00, pend_full = 0, in_ready = 1, scan counter = 0, digit = 0.
REQ-028 While rst is high, the seg/an registers SHALL hold digit 0 displaying '0' with dp off; with ACTIVE_LOW == 1 this is seg = 8'b00000011 and an = 2'b10.
REQ-029 rst asserted mid-frame or mid-transfer SHALL discard pending data, with no partial update of shown.

Structure
REQ-030 A shared package SHALL hold the 16-entry hex-to-segment constant table and the seg bit-index constants.
REQ-031 Sub-module hex7seg SHALL contain the purely combinational nibble decoder; the top module owns the handshake, scan logic and output registers.

Verification (SCAN_DIV=4, ACTIVE_LOW=1, BLANK_LZ=0 unless stated)
REQ-032 Reset release -> seg = 8'b00000011 and an = 2'b10; an alternates every 4 cycles; shown = 8'h00.
REQ-033 Single byte: send 8'h3A with in_valid for 1 cycle -> in_ready = 0 until frame end; then shown = 8'h3A; digit 0 shows 'A' (seg = 8'b00010001), digit 1 shows '3' (seg = 8'b00001101).
REQ-034 Back-pressure: hold in_valid with 8'h11, then 8'h22 -> 8'h22 is accepted only after in_ready rises; shown sequence is 8'h11 then 8'h22, with no value lost.
REQ-035 Accept on the exact frame-end cycle -> shown unchanged at that edge and updated at the following frame end (8 cycles later).
REQ-036 BLANK_LZ=1, send 8'h05 -> digit 1 seg = 8'b11111111 and digit 0 shows '5'; then send 8'h00 -> digit 0 shows '0'.
REQ-037 Assert rst while pend_full = 1 -> pending is dropped, shown = 8'h00, in_ready = 1 immediately (asynchronously).
